id_stage: RTL
=============

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameters: FS_TO_DS_BUS_WD, 64, {inst[63:32], pc[31:0]}; DS_TO_ES_BUS_WD, 136, decoded bundle (REQ-012); BR_BUS_WD, 34, {br_stall, br_taken, br_target[31:0]}; FWD_BUS_WD, 39, {valid, gr_we, dest[4:0], data[31:0]}.
REQ-002 clk  in  1  clock; all state on rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 es_allowin  in  1  EX can accept this cycle.
REQ-005 ds_allowin  out  1  ID can accept from IF.
REQ-006 fs_to_ds_valid  in  1; fs_to_ds_bus  in  FS_TO_DS_BUS_WD.
REQ-007 ds_to_es_valid  out  1; ds_to_es_bus  out  DS_TO_ES_BUS_WD.
REQ-008 br_bus  out  BR_BUS_WD  branch/jump feedback to IF.
REQ-009 es_fwd_bus, ms_fwd_bus, ws_fwd_bus  in  FWD_BUS_WD each; es_is_load  in  1  EX holds a valid LW.
REQ-010 rf_raddr1, rf_raddr2  out  5; rf_rdata1, rf_rdata2  in  32  combinational regfile read ports.

Function
REQ-011 Handshake: ds_allowin = !ds_valid || (ds_ready_go && es_allowin); ds_to_es_valid = ds_valid && ds_ready_go; ds_valid <= fs_to_ds_valid when ds_allowin; inst/pc registers load only when fs_to_ds_valid && ds_allowin, else hold.
REQ-012 ds_to_es_bus MSB->LSB: alu_op[11:0] (add,sub,slt,sltu,and,nor,or,xor,sll,srl,sra,lui one-hot), load_op, store_op, src1_is_sa, src1_is_pc, src2_is_imm, src2_is_8, gr_we, dest[4:0], imm[15:0], rs_value[31:0], rt_value[31:0], pc[31:0].
REQ-013 Decoded set: ADDU, SUBU, SLT, SLTU, AND, OR, XOR, NOR, SLL, SRL, SRA, ADDIU, LUI, LW, SW, BEQ, BNE, JAL, JR; any other encoding = NOP (all flags 0, gr_we 0).
REQ-014 dest: rd for R-type, rt for ADDIU/LUI/LW, 31 for JAL; gr_we 0 for SW/BEQ/BNE/JR/NOP; JAL sets src1_is_pc, src2_is_8, alu add (link = pc+8).
REQ-015 Operand values: priority ES > MS > WS > regfile; a forward source matches when valid && gr_we && dest==addr && addr!=0; addr 0 always yields 0.
REQ-016 Load-use: ds_ready_go = 0 when es_fwd valid, es_is_load, es dest matches a used source (rs or rt, nonzero); otherwise ds_ready_go = 1.
REQ-017 ES forward data is never used when es_is_load (stall instead).
REQ-018 Targets: BEQ/BNE = pc+4+(sign_ext(imm)<<2); JAL = {pc_plus4[31:28], inst[25:0], 2'b00}; JR = rs_value; all 32-bit wrap-around.
REQ-019 br_taken = ds_valid && ds_ready_go && (JAL || JR || BEQ&&rs==rt || BNE&&rs!=rt), using forwarded values.
REQ-020 br_stall = ds_valid && (BEQ||BNE||JR) && !ds_ready_go; IF suppresses fetch while high.
REQ-021 Delay slot: the instruction in IF when br_taken asserts is accepted and executed normally; no squash logic in ID.
REQ-022 es_allowin low with ds_ready_go high: ds_valid, inst, pc hold; br_taken stays asserted, target stable.
REQ-023 Simultaneous load-use stall and es_allowin low: ds_ready_go 0 dominates; no bubble duplication, no instruction loss.

Reset
REQ-024 Reset: ds_valid=0, inst=0, pc=0; hence ds_to_es_valid=0, br_bus=0, ds_allowin=1 in the first post-reset cycle.
REQ-025 Reset asserted mid-stall discards the held instruction; no output depends on pre-reset state afterwards.

Verification
REQ-026 ADDU $3,$1,$2 with rf $1=5,$2=7, no forwards -> bus rs_value=5, rt_value=7, dest=3, gr_we=1, alu add, next cycle ds_to_es_valid=1.
REQ-027 ADDU $3,$1,$2 with es_fwd {1,1,1,0x10}, ms_fwd {1,1,1,0x20} -> rs_value=0x10 (ES priority).
REQ-028 es_is_load=1, es dest=2, ID holds BEQ $2,$0 -> br_stall=1, ds_to_es_valid=0, ds_allowin=0 one cycle; next cycle with ws_fwd {1,1,2,0} -> br_taken=1, target=pc+4+(imm<<2).
REQ-029 JAL at pc 0xBFC00010, index 0x0100000 -> br_taken=1, br_target=0xB0400000, dest=31, src1_is_pc=1, src2_is_8=1.
REQ-030 BNE at pc 0xFFFFFFF8, imm 0x0001 -> target 0x00000000 (wrap); ADDU $0 write with es_fwd dest=0 -> consumer reads 0.
REQ-031 Reset asserted while ds_valid=1 and es_allowin=0 -> next cycle ds_valid=0, br_bus=0, ds_allowin=1.

Source files
------------

// File: rtl/id_stage.sv
// Decode stage of the five-stage MIPS pipeline: instruction decode, operand
// forwarding, load-use interlock and branch/jump resolution fed back to IF.
module id_stage #(
  parameter int FS_TO_DS_BUS_WD = 64,
  parameter int DS_TO_ES_BUS_WD = 136,
  parameter int BR_BUS_WD       = 34,
  parameter int FWD_BUS_WD      = 39
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       es_allowin,
  output logic                       ds_allowin,
  input  logic                       fs_to_ds_valid,
  input  logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  output logic                       ds_to_es_valid,
  output logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  output logic [BR_BUS_WD-1:0]       br_bus,
  input  logic [FWD_BUS_WD-1:0]      es_fwd_bus,
  input  logic [FWD_BUS_WD-1:0]      ms_fwd_bus,
  input  logic [FWD_BUS_WD-1:0]      ws_fwd_bus,
  input  logic                       es_is_load,
  output logic [4:0]                 rf_raddr1,
  output logic [4:0]                 rf_raddr2,
  input  logic [31:0]                rf_rdata1,
  input  logic [31:0]                rf_rdata2
);

  localparam logic [11:0] ALU_ADD  = 12'h800;
  localparam logic [11:0] ALU_SUB  = 12'h400;
  localparam logic [11:0] ALU_SLT  = 12'h200;
  localparam logic [11:0] ALU_SLTU = 12'h100;
  localparam logic [11:0] ALU_AND  = 12'h080;
  localparam logic [11:0] ALU_NOR  = 12'h040;
  localparam logic [11:0] ALU_OR   = 12'h020;
  localparam logic [11:0] ALU_XOR  = 12'h010;
  localparam logic [11:0] ALU_SLL  = 12'h008;
  localparam logic [11:0] ALU_SRL  = 12'h004;
  localparam logic [11:0] ALU_SRA  = 12'h002;
  localparam logic [11:0] ALU_LUI  = 12'h001;

  logic        ds_valid;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        ds_ready_go;

  always_ff @(posedge clk) begin
    if (reset) begin
      ds_valid <= 1'b0;
      inst     <= '0;
      pc       <= '0;
    end else begin
      if (ds_allowin) ds_valid <= fs_to_ds_valid;
      if (fs_to_ds_valid && ds_allowin) begin
        inst <= fs_to_ds_bus[63:32];
        pc   <= fs_to_ds_bus[31:0];
      end
    end
  end

  assign ds_allowin     = !ds_valid || (ds_ready_go && es_allowin);
  assign ds_to_es_valid = ds_valid && ds_ready_go;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  assign op    = inst[31:26];
  assign rs    = inst[25:21];
  assign rt    = inst[20:16];
  assign rd    = inst[15:11];
  assign imm   = inst[15:0];
  assign funct = inst[5:0];

  logic [11:0] alu_op;
  logic        load_op, store_op, src1_is_sa, src1_is_pc, src2_is_imm, src2_is_8, gr_we;
  logic [4:0]  dest;
  logic        is_beq, is_bne, is_jal, is_jr, rs_used, rt_used;

  always_comb begin
    alu_op = '0; load_op = 1'b0; store_op = 1'b0; src1_is_sa = 1'b0; src1_is_pc = 1'b0;
    src2_is_imm = 1'b0; src2_is_8 = 1'b0; gr_we = 1'b0; dest = '0;
    is_beq = 1'b0; is_bne = 1'b0; is_jal = 1'b0; is_jr = 1'b0; rs_used = 1'b0; rt_used = 1'b0;
    case (op)
      6'h00: begin
        case (funct)
          6'h21: alu_op = ALU_ADD;
          6'h23: alu_op = ALU_SUB;
          6'h2a: alu_op = ALU_SLT;
          6'h2b: alu_op = ALU_SLTU;
          6'h24: alu_op = ALU_AND;
          6'h27: alu_op = ALU_NOR;
          6'h25: alu_op = ALU_OR;
          6'h26: alu_op = ALU_XOR;
          6'h00: begin alu_op = ALU_SLL; src1_is_sa = 1'b1; end
          6'h02: begin alu_op = ALU_SRL; src1_is_sa = 1'b1; end
          6'h03: begin alu_op = ALU_SRA; src1_is_sa = 1'b1; end
          6'h08: begin is_jr = 1'b1; rs_used = 1'b1; end
          default: ;
        endcase
        // Common tail for every R-type ALU op; shifts take sa instead of rs.
        if (alu_op != '0) begin
          gr_we = 1'b1; dest = rd; rt_used = 1'b1; rs_used = !src1_is_sa;
        end
      end
      6'h09: begin alu_op = ALU_ADD; src2_is_imm = 1'b1; gr_we = 1'b1; dest = rt; rs_used = 1'b1; end
      6'h0f: begin alu_op = ALU_LUI; src2_is_imm = 1'b1; gr_we = 1'b1; dest = rt; end
      6'h23: begin
        alu_op = ALU_ADD; load_op = 1'b1; src2_is_imm = 1'b1; gr_we = 1'b1; dest = rt; rs_used = 1'b1;
      end
      6'h2b: begin
        alu_op = ALU_ADD; store_op = 1'b1; src2_is_imm = 1'b1; rs_used = 1'b1; rt_used = 1'b1;
      end
      6'h04: begin is_beq = 1'b1; rs_used = 1'b1; rt_used = 1'b1; end
      6'h05: begin is_bne = 1'b1; rs_used = 1'b1; rt_used = 1'b1; end
      6'h03: begin
        alu_op = ALU_ADD; src1_is_pc = 1'b1; src2_is_8 = 1'b1; gr_we = 1'b1; dest = 5'd31; is_jal = 1'b1;
      end
      default: ;
    endcase
  end

  // ES result is skipped while it is a load; the interlock below covers that case.
  function automatic logic [31:0] operand(input logic [4:0] a, input logic [31:0] rf,
                                          input logic [FWD_BUS_WD-1:0] es, ms, ws,
                                          input logic es_ld);
    if (a == 5'd0) return '0;
    if (es[38] && es[37] && es[36:32] == a && !es_ld) return es[31:0];
    if (ms[38] && ms[37] && ms[36:32] == a) return ms[31:0];
    if (ws[38] && ws[37] && ws[36:32] == a) return ws[31:0];
    return rf;
  endfunction

  logic [31:0] rs_value, rt_value;
  assign rs_value = operand(rs, rf_rdata1, es_fwd_bus, ms_fwd_bus, ws_fwd_bus, es_is_load);
  assign rt_value = operand(rt, rf_rdata2, es_fwd_bus, ms_fwd_bus, ws_fwd_bus, es_is_load);

  assign ds_ready_go = !(es_fwd_bus[38] && es_is_load &&
                         ((rs_used && rs != 5'd0 && es_fwd_bus[36:32] == rs) ||
                          (rt_used && rt != 5'd0 && es_fwd_bus[36:32] == rt)));

  logic [31:0] pc_plus4, br_target;
  logic        br_taken, br_stall;
  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    br_target = '0;
    if (ds_valid) begin
      if (is_jal)               br_target = {pc_plus4[31:28], inst[25:0], 2'b00};
      else if (is_jr)           br_target = rs_value;
      else if (is_beq || is_bne) br_target = pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
    end
  end

  assign br_taken = ds_valid && ds_ready_go &&
                    (is_jal || is_jr || (is_beq && rs_value == rt_value) ||
                     (is_bne && rs_value != rt_value));
  assign br_stall = ds_valid && (is_beq || is_bne || is_jr) && !ds_ready_go;
  assign br_bus   = {br_stall, br_taken, br_target};

  assign ds_to_es_bus = {alu_op, load_op, store_op, src1_is_sa, src1_is_pc, src2_is_imm,
                         src2_is_8, gr_we, dest, imm, rs_value, rt_value, pc};
  assign rf_raddr1 = rs;
  assign rf_raddr2 = rt;

endmodule
